// File: rtl/except_ctrl.sv
// MEM-stage exception resolver: combinational excepttype to CP0 (zero latency), registered flush/new_pc one edge later.
// After an exception the flush is held FLUSH_CYCLES cycles; commits are masked (excepttype_o=0) until it drops.
module except_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_excepttype_i,
  input  logic [31:0] mem_current_inst_addr_i,
  input  logic        mem_is_in_delayslot_i,
  input  logic        mem_inst_valid_i,
  input  logic        mem_stall_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] cp0_epc_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0]  CNT_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [31:0] EXC_INT   = 32'h1;
  localparam logic [31:0] EXC_SYS   = 32'h8;
  localparam logic [31:0] EXC_INV   = 32'ha;
  localparam logic [31:0] EXC_TRAP  = 32'hd;
  localparam logic [31:0] EXC_OV    = 32'hc;
  localparam logic [31:0] EXC_ERET  = 32'he;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        flush_n;
  logic [31:0] new_pc_n;
  logic [31:0] status_f, cause_f, epc_f;
  logic        commit, int_pend;
  logic        unused_bits;

  // Same-cycle WB mtc0 overrides the CP0 register file view
  always_comb begin
    status_f = cp0_status_i;
    cause_f  = cp0_cause_i;
    epc_f    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        5'd12: status_f = wb_cp0_data_i;
        5'd13: cause_f  = {cp0_cause_i[31:24], wb_cp0_data_i[23:22], cp0_cause_i[21:10],
                           wb_cp0_data_i[9:8], cp0_cause_i[7:0]};
        5'd14: epc_f    = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  assign unused_bits = ^{mem_excepttype_i[31:13], mem_excepttype_i[7:0], status_f[31:16],
                         status_f[7:2], cause_f[31:16], cause_f[7:0]};

  assign commit   = mem_inst_valid_i && !mem_stall_i && (state == IDLE) &&
                    (mem_current_inst_addr_i != 32'd0) && !rst;
  assign int_pend = ((status_f[15:8] & cause_f[15:8]) != 8'd0) && !status_f[1] && status_f[0];

  always_comb begin
    excepttype_o = 32'd0;
    if (commit) begin
      if (int_pend)                 excepttype_o = EXC_INT;
      else if (mem_excepttype_i[8])  excepttype_o = EXC_SYS;
      else if (mem_excepttype_i[9])  excepttype_o = EXC_INV;
      else if (mem_excepttype_i[10]) excepttype_o = EXC_TRAP;
      else if (mem_excepttype_i[11]) excepttype_o = EXC_OV;
      else if (mem_excepttype_i[12]) excepttype_o = EXC_ERET;
    end
  end

  assign current_inst_addr_o = mem_current_inst_addr_i;
  assign is_in_delayslot_o   = mem_is_in_delayslot_i;
  assign cp0_epc_o           = epc_f;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    flush_n  = flush_o;
    new_pc_n = new_pc_o;
    case (state)
      IDLE: begin
        if (excepttype_o != 32'd0) begin
          state_n  = FLUSH;
          cnt_n    = CNT_INIT;
          flush_n  = 1'b1;
          new_pc_n = (excepttype_o == EXC_ERET) ? epc_f : EXC_VECTOR;
        end
      end
      FLUSH: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n = IDLE;
          flush_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      flush_o  <= 1'b0;
      new_pc_o <= 32'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      flush_o  <= flush_n;
      new_pc_o <= new_pc_n;
    end
  end

endmodule
